// File: rtl/load_store_unit_if.sv
// Core/memory-side signal bundle for load_store_unit.
// slave is the LSU's view; master is the view of whatever drives it (core + memory model).
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    lsu_req;
  logic                    lsu_we;
  logic [2:0]              lsu_funct3;
  logic [ADDR_WIDTH-1:0]   lsu_addr;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic [DATA_WIDTH-1:0]   lsu_rdata;
  logic                    lsu_busy;
  logic                    lsu_done;
  logic                    lsu_err;
  logic [1:0]              lsu_err_code;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ack;

  modport slave (
    input  lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_rdata, mem_ack,
    output lsu_rdata, lsu_busy, lsu_done, lsu_err, lsu_err_code,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_rdata, mem_ack,
    input  lsu_rdata, lsu_busy, lsu_done, lsu_err, lsu_err_code,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I/RV64 byte/half/word/double load-store unit with byte lanes, strobes,
// ack timeout and sign/zero extension. All outputs are registered.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              lsu_clk,
  input logic              lsu_rst,
  load_store_unit_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                we_q, we_nxt;
  logic [2:0]          f3_q, f3_nxt;
  logic [LANE_W-1:0]   lane_q, lane_nxt;
  logic                err_pend, err_pend_nxt;
  logic [1:0]          code_pend, code_pend_nxt;

  logic                    busy_nxt, done_nxt, err_nxt;
  logic [1:0]              code_nxt;
  logic [DATA_WIDTH-1:0]   rdata_nxt;
  logic                    mreq_nxt, mwe_nxt;
  logic [ADDR_WIDTH-1:0]   maddr_nxt;
  logic [STRB_W-1:0]       mstrb_nxt;
  logic [DATA_WIDTH-1:0]   mwdata_nxt;

  // request decode, evaluated on the live inputs while idle
  logic              legal, misal;
  logic [LANE_W-1:0] lane;
  logic [STRB_W-1:0] strobe;
  int                size;

  assign lane = bus.lsu_addr[LANE_W-1:0];
  assign size = 1 << bus.lsu_funct3[1:0];

  always_comb begin
    legal = 1'b0;
    if (bus.lsu_we) begin
      case (bus.lsu_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (DATA_WIDTH == 64);
        default:                legal = 1'b0;
      endcase
    end else begin
      case (bus.lsu_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (DATA_WIDTH == 64);
        default:                                legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    misal = 1'b0;
    case (bus.lsu_funct3[1:0])
      2'd0:    misal = 1'b0;
      2'd1:    misal = bus.lsu_addr[0];
      2'd2:    misal = |bus.lsu_addr[1:0];
      default: misal = |bus.lsu_addr[2:0];
    endcase
  end

  always_comb begin
    strobe = '0;
    for (int i = 0; i < STRB_W; i++)
      strobe[i] = (i >= int'(lane)) && (i < int'(lane) + size);
  end

  // load extraction: shift the lane down, keep `size` bytes, fill the rest
  logic [DATA_WIDTH-1:0] sh, keep, ext;
  logic                  sgn;

  always_comb begin
    sh   = bus.mem_rdata >> {lane_q, 3'b000};
    keep = '0;
    for (int i = 0; i < STRB_W; i++)
      keep[8*i +: 8] = {8{i < (1 << f3_q[1:0])}};
    case (f3_q[1:0])
      2'd0:    sgn = sh[7];
      2'd1:    sgn = sh[15];
      2'd2:    sgn = sh[31];
      default: sgn = sh[DATA_WIDTH-1];
    endcase
    ext = (sh & keep) | ((sgn && !f3_q[2]) ? ~keep : '0);
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    we_nxt        = we_q;
    f3_nxt        = f3_q;
    lane_nxt      = lane_q;
    err_pend_nxt  = err_pend;
    code_pend_nxt = code_pend;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    code_nxt      = ERR_NONE;
    rdata_nxt     = bus.lsu_rdata;
    mreq_nxt      = bus.mem_req;
    mwe_nxt       = bus.mem_we;
    maddr_nxt     = bus.mem_addr;
    mstrb_nxt     = bus.mem_wstrb;
    mwdata_nxt    = bus.mem_wdata;

    case (state)
      S_IDLE: begin
        if (bus.lsu_req) begin
          we_nxt   = bus.lsu_we;
          f3_nxt   = bus.lsu_funct3;
          lane_nxt = lane;
          cnt_nxt  = '0;
          if (!legal) begin
            state_nxt     = S_DONE;
            err_pend_nxt  = 1'b1;
            code_pend_nxt = ERR_ILL;
          end else if (misal) begin
            state_nxt     = S_DONE;
            err_pend_nxt  = 1'b1;
            code_pend_nxt = ERR_ALIGN;
          end else begin
            state_nxt  = S_WAIT;
            busy_nxt   = 1'b1;
            mreq_nxt   = 1'b1;
            mwe_nxt    = bus.lsu_we;
            maddr_nxt  = {bus.lsu_addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
            mstrb_nxt  = bus.lsu_we ? strobe : '0;
            mwdata_nxt = bus.lsu_we ? (bus.lsu_wdata << {lane, 3'b000}) : '0;
          end
        end
      end
      S_WAIT: begin
        busy_nxt = 1'b1;
        // ack is checked before the count so a last-cycle ack still succeeds
        if (bus.mem_ack) begin
          state_nxt     = S_DONE;
          busy_nxt      = 1'b0;
          mreq_nxt      = 1'b0;
          err_pend_nxt  = 1'b0;
          code_pend_nxt = ERR_NONE;
          if (!we_q) rdata_nxt = ext;
        end else if (cnt == TMO_LAST) begin
          state_nxt     = S_DONE;
          busy_nxt      = 1'b0;
          mreq_nxt      = 1'b0;
          err_pend_nxt  = 1'b1;
          code_pend_nxt = ERR_TMO;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        done_nxt  = 1'b1;
        err_nxt   = err_pend;
        code_nxt  = code_pend;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      we_q             <= 1'b0;
      f3_q             <= '0;
      lane_q           <= '0;
      err_pend         <= 1'b0;
      code_pend        <= ERR_NONE;
      bus.lsu_rdata    <= '0;
      bus.lsu_busy     <= 1'b0;
      bus.lsu_done     <= 1'b0;
      bus.lsu_err      <= 1'b0;
      bus.lsu_err_code <= ERR_NONE;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wstrb    <= '0;
      bus.mem_wdata    <= '0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      we_q             <= we_nxt;
      f3_q             <= f3_nxt;
      lane_q           <= lane_nxt;
      err_pend         <= err_pend_nxt;
      code_pend        <= code_pend_nxt;
      bus.lsu_rdata    <= rdata_nxt;
      bus.lsu_busy     <= busy_nxt;
      bus.lsu_done     <= done_nxt;
      bus.lsu_err      <= err_nxt;
      bus.lsu_err_code <= code_nxt;
      bus.mem_req      <= mreq_nxt;
      bus.mem_we       <= mwe_nxt;
      bus.mem_addr     <= maddr_nxt;
      bus.mem_wstrb    <= mstrb_nxt;
      bus.mem_wdata    <= mwdata_nxt;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: 32-bit LSU with a 4-cycle timeout and a 64-bit LSU, shared clock/reset.
module tb_load_store_unit;
  logic lsu_clk = 1'b0;
  logic lsu_rst = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  int   n;

  always #5 lsu_clk = ~lsu_clk;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
  load_store_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
    .lsu_clk(lsu_clk), .lsu_rst(lsu_rst), .bus(b32.slave));
  load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut64 (
    .lsu_clk(lsu_clk), .lsu_rst(lsu_rst), .bus(b64.slave));

  task automatic tick();
    @(posedge lsu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present a request for exactly one edge on the 32-bit unit
  task automatic req32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    b32.lsu_req = 1'b1; b32.lsu_we = we; b32.lsu_funct3 = f3;
    b32.lsu_addr = addr; b32.lsu_wdata = wdata;
    tick();
    b32.lsu_req = 1'b0;
  endtask

  task automatic req64(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wdata);
    b64.lsu_req = 1'b1; b64.lsu_we = we; b64.lsu_funct3 = f3;
    b64.lsu_addr = addr; b64.lsu_wdata = wdata;
    tick();
    b64.lsu_req = 1'b0;
  endtask

  initial begin
    b32.lsu_req = 0; b32.lsu_we = 0; b32.lsu_funct3 = 0; b32.lsu_addr = 0;
    b32.lsu_wdata = 0; b32.mem_rdata = 0; b32.mem_ack = 0;
    b64.lsu_req = 0; b64.lsu_we = 0; b64.lsu_funct3 = 0; b64.lsu_addr = 0;
    b64.lsu_wdata = 0; b64.mem_rdata = 0; b64.mem_ack = 0;

    tick(); tick();
    chk("rst_rdata", b32.lsu_rdata, 0);
    chk("rst_busy", b32.lsu_busy, 0);
    chk("rst_done", b32.lsu_done, 0);
    chk("rst_mem_req", b32.mem_req, 0);
    chk("rst64_mem_addr", b64.mem_addr, 0);
    lsu_rst = 1'b0;

    // LB 0x103, ack after two wait cycles
    req32(1'b0, 3'b000, 32'h103, 0);
    chk("lb_mem_req", b32.mem_req, 1);
    chk("lb_busy", b32.lsu_busy, 1);
    chk("lb_mem_addr", b32.mem_addr, 32'h100);
    chk("lb_wstrb", b32.mem_wstrb, 4'b0000);
    chk("lb_mem_we", b32.mem_we, 0);
    tick(); tick();
    chk("lb_req_held", b32.mem_req, 1);
    b32.mem_rdata = 32'h80FF_1234; b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    chk("lb_req_drop", b32.mem_req, 0);
    chk("lb_done_early", b32.lsu_done, 0);
    tick();
    chk("lb_done", b32.lsu_done, 1);
    chk("lb_err", b32.lsu_err, 0);
    chk("lb_rdata", b32.lsu_rdata, 32'hFFFF_FF80);
    tick();
    chk("lb_done_pulse", b32.lsu_done, 0);

    // LBU same address
    req32(1'b0, 3'b100, 32'h103, 0);
    tick();
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    tick();
    chk("lbu_done", b32.lsu_done, 1);
    chk("lbu_rdata", b32.lsu_rdata, 32'h0000_0080);
    tick();

    // SH 0x202, single-cycle ack: done three edges after the request edge
    req32(1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
    chk("sh_mem_addr", b32.mem_addr, 32'h200);
    chk("sh_wstrb", b32.mem_wstrb, 4'b1100);
    chk("sh_wdata", b32.mem_wdata, 32'hABCD_0000);
    chk("sh_mem_we", b32.mem_we, 1);
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    tick();
    chk("sh_done", b32.lsu_done, 1);
    chk("sh_err", b32.lsu_err, 0);
    chk("sh_rdata_hold", b32.lsu_rdata, 32'h0000_0080);
    tick();

    // misaligned LW
    req32(1'b0, 3'b010, 32'h105, 0);
    chk("mis_no_req", b32.mem_req, 0);
    chk("mis_done_early", b32.lsu_done, 0);
    tick();
    chk("mis_done", b32.lsu_done, 1);
    chk("mis_err", b32.lsu_err, 1);
    chk("mis_code", b32.lsu_err_code, 2'b01);
    tick();

    // funct3 011 at 32 bits, also misaligned: illegal wins
    req32(1'b0, 3'b011, 32'h101, 0);
    chk("ill_no_req", b32.mem_req, 0);
    tick();
    chk("ill_done", b32.lsu_done, 1);
    chk("ill_code", b32.lsu_err_code, 2'b11);
    tick();

    // store with a load-only funct3
    req32(1'b1, 3'b100, 32'h100, 0);
    tick();
    chk("ill_st_code", b32.lsu_err_code, 2'b11);
    tick();

    // timeout: mem_req high exactly four cycles
    req32(1'b0, 3'b010, 32'h100, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_req_high", b32.mem_req, 1);
    end
    tick();
    chk("tmo_req_low", b32.mem_req, 0);
    chk("tmo_done_early", b32.lsu_done, 0);
    tick();
    chk("tmo_done", b32.lsu_done, 1);
    chk("tmo_err", b32.lsu_err, 1);
    chk("tmo_code", b32.lsu_err_code, 2'b10);
    chk("tmo_rdata_hold", b32.lsu_rdata, 32'h0000_0080);
    tick();

    // ack on the final counted cycle wins
    req32(1'b0, 3'b010, 32'h108, 0);
    tick(); tick(); tick();
    b32.mem_rdata = 32'h1234_5678; b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    chk("ack4_req_low", b32.mem_req, 0);
    tick();
    chk("ack4_done", b32.lsu_done, 1);
    chk("ack4_err", b32.lsu_err, 0);
    chk("ack4_code", b32.lsu_err_code, 2'b00);
    chk("ack4_rdata", b32.lsu_rdata, 32'h1234_5678);
    tick();

    // reset during WAIT discards the store
    req32(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF);
    chk("sw_mem_we", b32.mem_we, 1);
    chk("sw_wstrb", b32.mem_wstrb, 4'b1111);
    chk("sw_wdata", b32.mem_wdata, 32'hDEAD_BEEF);
    tick();
    lsu_rst = 1'b1;
    tick();
    lsu_rst = 1'b0;
    chk("midrst_mem_req", b32.mem_req, 0);
    chk("midrst_mem_we", b32.mem_we, 0);
    chk("midrst_mem_addr", b32.mem_addr, 0);
    chk("midrst_wstrb", b32.mem_wstrb, 0);
    chk("midrst_wdata", b32.mem_wdata, 0);
    chk("midrst_rdata", b32.lsu_rdata, 0);
    chk("midrst_busy", b32.lsu_busy, 0);
    b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b32.lsu_done) n++;
    end
    chk("midrst_no_done", n, 0);

    // request held while busy is ignored
    b32.lsu_req = 1'b1; b32.lsu_we = 1'b0; b32.lsu_funct3 = 3'b000; b32.lsu_addr = 32'h101;
    tick();
    b32.lsu_we = 1'b1; b32.lsu_addr = 32'h200;
    tick();
    b32.lsu_req = 1'b0;
    chk("busy_addr_kept", b32.mem_addr, 32'h100);
    chk("busy_we_kept", b32.mem_we, 0);
    b32.mem_rdata = 32'h0000_7F00; b32.mem_ack = 1'b1;
    tick();
    b32.mem_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (b32.lsu_done) n++;
      tick();
    end
    chk("busy_one_done", n, 1);
    chk("busy_rdata", b32.lsu_rdata, 32'h0000_007F);

    // 64-bit unit: LWU / LW at lane 4
    req64(1'b0, 3'b110, 32'h14, 0);
    chk("lwu_mem_addr", b64.mem_addr, 32'h10);
    chk("lwu_wstrb", b64.mem_wstrb, 8'h00);
    b64.mem_rdata = 64'h8765_4321_0000_0000; b64.mem_ack = 1'b1;
    tick();
    b64.mem_ack = 1'b0;
    tick();
    chk("lwu_done", b64.lsu_done, 1);
    chk("lwu_rdata", b64.lsu_rdata, 64'h0000_0000_8765_4321);
    tick();

    req64(1'b0, 3'b010, 32'h14, 0);
    b64.mem_ack = 1'b1;
    tick();
    b64.mem_ack = 1'b0;
    tick();
    chk("lw64_rdata", b64.lsu_rdata, 64'hFFFF_FFFF_8765_4321);
    tick();

    req64(1'b1, 3'b011, 32'h8, 64'h1122_3344_5566_7788);
    chk("sd_wstrb", b64.mem_wstrb, 8'hFF);
    chk("sd_wdata", b64.mem_wdata, 64'h1122_3344_5566_7788);
    b64.mem_ack = 1'b1;
    tick();
    b64.mem_ack = 1'b0;
    tick();
    chk("sd_err", b64.lsu_err, 0);
    chk("sd_rdata_hold", b64.lsu_rdata, 64'hFFFF_FFFF_8765_4321);
    tick();

    req64(1'b0, 3'b011, 32'h14, 0);
    tick();
    chk("ld_mis_code", b64.lsu_err_code, 2'b01);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit between the multi-cycle core's control unit and data memory, replacing the fixed word-only MAR/MDR access path. It accepts one load or store per request, supports RV32I byte/halfword/word accesses (plus doubleword when DATA_WIDTH = 64), and drives the memory with byte lanes and strobes. It waits on a memory acknowledge handshake with timeout, sign/zero-extends load data, and reports misaligned, illegal and timed-out accesses instead of silently corrupting state.

## Interface
- DATA_WIDTH, 32, data path width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, maximum wait-for-ack cycles before abort; ≥1.

- lsu_clk  in  1  sole clock; all state changes on rising edge.
- lsu_rst  in  1  synchronous, active-high reset.
- lsu_req  in  1  request strobe; sampled only in IDLE.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RISC-V funct3 access size/sign.
- lsu_addr  in  ADDR_WIDTH  byte address.
- lsu_wdata  in  DATA_WIDTH  store data, right-aligned.
- lsu_rdata  out  DATA_WIDTH  extended load result.
- lsu_busy  out  1  high from the cycle after accept until done.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_err  out  1  valid with lsu_done; access failed.
- lsu_err_code  out  2  01 misaligned, 10 timeout, 11 illegal funct3, 00 none.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  lane-aligned address (low log2(DATA_WIDTH/8) bits zero).
- mem_wstrb  out  DATA_WIDTH/8  byte write strobes.
- mem_wdata  out  DATA_WIDTH  lane-shifted store data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.

## Operation
- States: IDLE, WAIT, DONE. All outputs registered.
- IDLE, lsu_req=1: latch we/funct3/addr/wdata, then decode:
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; DATA_WIDTH=64 adds 011 LD, 110 LWU. Legal stores: 000 SB, 001 SH, 010 SW; DATA_WIDTH=64 adds 011 SD. Anything else → DONE, err 11.
  - Size = 2^funct3[1:0] bytes; misaligned if addr mod size ≠ 0 → DONE, err 01 (illegal checked first).
  - Otherwise → WAIT, assert mem_req, mem_we=lsu_we, mem_addr, mem_wstrb, mem_wdata; lane = addr low bits; strobe = ((1<<size)-1)<<lane; mem_wdata = wdata<<(8·lane). Loads drive mem_wstrb=0.
- WAIT: count cycles from 0. mem_ack=1 → drop mem_req; load: lsu_rdata = (mem_rdata>>(8·lane)) truncated to size, sign-extended if funct3[2]=0, zero-extended otherwise → DONE, err 00. Count reaches TIMEOUT_CYCLES without ack → drop mem_req → DONE, err 10.
- DONE: lsu_done=1 for one cycle with lsu_err/lsu_err_code → IDLE.
- lsu_rdata updated only on successful load; holds across stores and errors.
- lsu_req outside IDLE ignored (not queued). mem_ack outside WAIT ignored.

## Timing
- Reset: state IDLE, every output 0 (lsu_rdata 0, mem_* 0, counter 0) on the edge where lsu_rst=1; reset overrides any state, including mid-WAIT (mem_req low after that edge, request discarded, no lsu_done).
- Accepted request at edge N: mem_req and lsu_busy high after N.
- Ack sampled at edge M (≥N+1): lsu_done high for cycle after M+1; minimum request-to-done = 3 edges with single-cycle ack.
- Error (misaligned/illegal): lsu_done after edge N+1; mem_req never asserted.
- Timeout: ack and final count on same edge → ack wins, success.
- lsu_busy low in IDLE and DONE; new request accepted in the cycle after lsu_done.

## Test plan
- DATA_WIDTH=32, load LB addr 0x103, mem_rdata 0x80FF_1234, ack after 2 wait cycles → mem_addr 0x100, wstrb 0000, lsu_rdata 0xFFFF_FF80, err 0; LBU same → 0x0000_0080.
- Store SH addr 0x202, wdata 0x0000_ABCD → mem_addr 0x200, wstrb 1100, mem_wdata 0xABCD_0000, mem_we 1, done err 0, lsu_rdata unchanged.
- LW addr 0x105 → no mem_req, lsu_done 2 edges after accept, err 1, code 01; funct3 011 at DATA_WIDTH=32 → code 11.
- TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles, then done, code 10; repeat with ack on 4th cycle → success.
- DATA_WIDTH=64, LWU addr 0x14, mem_rdata 0x8765_4321_0000_0000 → mem_addr 0x10, lsu_rdata 0x0000_0000_8765_4321; LW → 0xFFFF_FFFF_8765_4321.
- Assert lsu_rst during WAIT, then ack → all outputs 0 after the reset edge, no lsu_done; lsu_req while busy → ignored, exactly one lsu_done.
